rx_frame_parser: RTL and testbench
==================================

RX_FRAME_PARSER -- requirements
Module: rx_frame_parser

Interface
REQ-001 SHALL provide parameter DEV_ID, default 16'h0001, the device ID that a frame's ID1/ID2 must match.
REQ-002 SHALL provide parameter MAX_LEN, default 4, the maximum accepted payload byte count (1..4).
REQ-003 SHALL provide parameter TIMEOUT_CYC, default 50000, the maximum idle clocks allowed between bytes inside a frame.
REQ-004 SHALL have port sys_clk, input, 1 bit: clock; all logic on the rising edge.
REQ-005 SHALL have port sys_rst, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port rx_data, input, 8 bits: received byte from the UART receive block.
REQ-007 SHALL have port rx_data_flag, input, 1 bit: one-cycle pulse marking rx_data valid.
REQ-008 SHALL have port cmd, output, 8 bits: first payload byte of an accepted frame.
REQ-009 SHALL have port cmd_arg, output, 24 bits: payload bytes 2..4, left-justified; missing bytes are 0.
REQ-010 SHALL have port cmd_len, output, 3 bits: payload byte count of the accepted frame.
REQ-011 SHALL have port cmd_flag, output, 1 bit: one-cycle pulse marking cmd, cmd_arg and cmd_len valid.
REQ-012 SHALL have port frame_err, output, 1 bit: one-cycle pulse on a length, checksum or timeout error.
REQ-013 SHALL have port rx_busy, output, 1 bit: high whenever the state is not S_ID1.

Function
REQ-014 SHALL use the frame format ID1, ID2, CNT1, CNT2, payload[CNT], CHK1, CHK2, with the ID, CNT and CHK fields big-endian.
REQ-015 SHALL compute the checksum as the 16-bit modulo-2^16 sum of ID1 through the last payload byte; CHK1 is the high byte and CHK2 the low byte.
REQ-016 SHALL implement the states S_ID1 (idle), S_ID2, S_CNT1, S_CNT2, S_DATA, S_CHK1 and S_CHK2.
REQ-017 SHALL advance the state only on a cycle where rx_data_flag=1, except for the timeout exit.
REQ-018 SHALL take the following transitions:
- S_ID1 -> S_ID2: sum is loaded with the byte.
- S_ID2 -> S_CNT1: id_ok is set to ({ID1,ID2}==DEV_ID).
- S_CNT1 -> S_CNT2.
- S_CNT2 -> S_DATA when 1 <= {CNT1,CNT2} <= MAX_LEN; otherwise -> S_ID1 with a frame_err pulse.
- S_DATA -> S_CHK1 after CNT bytes.
- S_CHK1 -> S_CHK2.
- S_CHK2 -> S_ID1.
REQ-019 SHALL accumulate every byte from ID1 through the last payload byte into the 16-bit sum, with wrap-around and no saturation.
REQ-020 SHALL store payload bytes into a 32-bit buffer at [31:24], [23:16], [15:8], [7:0] in arrival order; the buffer is cleared at frame start.
REQ-021 SHALL, on the CHK2 byte, assert the checksum-error case when {CHK1,CHK2} != sum: a frame_err pulse and no cmd_flag, regardless of id_ok.
REQ-022 SHALL, on the CHK2 byte, silently drop the frame when the checksum matches and id_ok=0: no cmd_flag and no frame_err.
REQ-023 SHALL, on the CHK2 byte with a matching checksum and id_ok=1, register cmd=buf[31:24], cmd_arg=buf[23:0] and cmd_len=CNT, and pulse cmd_flag.
REQ-024 SHALL drive cmd_flag and frame_err exactly one clock after the rx_data_flag cycle of the deciding byte, high for exactly one clock.
REQ-025 SHALL hold cmd, cmd_arg and cmd_len until the next accepted frame.
REQ-026 SHALL clear the timeout counter on every rx_data_flag and while in S_ID1, and increment it otherwise.
REQ-027 SHALL, when the timeout counter reaches TIMEOUT_CYC-1 outside S_ID1, return to S_ID1 and pulse frame_err.
REQ-028 SHALL give a byte arriving on the same cycle as the timeout priority: the byte is processed and the timeout is ignored.
REQ-029 SHALL, after any error or drop, treat the next byte as ID1 with no resynchronisation delay.
REQ-030 SHALL accept back-to-back frames with consecutive rx_data_flag pulses one clock apart.

Reset
REQ-031 SHALL, on sys_rst=0 at any time including mid-frame, immediately force state=S_ID1, cmd=8'h00, cmd_arg=24'h0, cmd_len=0, cmd_flag=0, frame_err=0, rx_busy=0, sum=0, buffer=0 and timeout counter=0.
REQ-032 SHALL, after sys_rst is released, discard any partial frame and parse the first byte received as ID1.

Verification
REQ-033 SHALL cover a valid 1-byte frame: bytes 00 01 00 01 05 00 07 -> cmd=8'h05, cmd_arg=0, cmd_len=1, one cmd_flag pulse, frame_err=0.
REQ-034 SHALL cover a valid 4-byte frame: bytes 00 01 00 04 11 22 33 44 00 AF -> cmd=8'h11, cmd_arg=24'h223344, cmd_len=4, one cmd_flag pulse.
REQ-035 SHALL cover a bad checksum: bytes 00 01 00 01 05 00 08 -> one frame_err pulse, no cmd_flag, cmd outputs unchanged; a following valid frame is accepted.
REQ-036 SHALL cover an ID mismatch: bytes 00 02 00 01 05 00 08 -> neither cmd_flag nor frame_err, rx_busy low after the last byte.
REQ-037 SHALL cover a length error: bytes 00 01 00 05 -> frame_err one clock after the CNT2 byte and state=S_ID1; likewise for CNT=0.
REQ-038 SHALL cover a timeout: bytes 00 01 then no bytes for TIMEOUT_CYC clocks -> one frame_err pulse and rx_busy=0; a valid frame then yields cmd_flag; an asynchronous reset asserted mid-frame clears all outputs immediately.

Source files
------------

// File: rtl/rx_frame_parser.sv
// rx_frame_parser: decodes ID/CNT/payload/CHK frames from a UART byte stream into commands,
// flagging length, checksum and inter-byte timeout errors.
module rx_frame_parser #(
  parameter logic [15:0] DEV_ID      = 16'h0001,
  parameter int          MAX_LEN     = 4,
  parameter int          TIMEOUT_CYC = 50000
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_data_flag,
  output logic [7:0]  cmd,
  output logic [23:0] cmd_arg,
  output logic [2:0]  cmd_len,
  output logic        cmd_flag,
  output logic        frame_err,
  output logic        rx_busy
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  typedef enum logic [2:0] {S_ID1, S_ID2, S_CNT1, S_CNT2, S_DATA, S_CHK1, S_CHK2} state_t;
  state_t        state;
  logic [15:0]   sum;
  logic [31:0]   buffer;
  logic [7:0]    id1, cnt1, chk1;
  logic [2:0]    len;
  logic [1:0]    idx;
  logic          id_ok;
  logic [TW-1:0] tmo;
  logic [15:0]   sum_next, cnt_full;
  logic          cnt_ok;
  assign rx_busy  = state != S_ID1;
  assign sum_next = sum + {8'h00, rx_data};
  assign cnt_full = {cnt1, rx_data};
  assign cnt_ok   = cnt_full != 16'd0 && cnt_full <= 16'(MAX_LEN);
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state     <= S_ID1;
      sum       <= '0;
      buffer    <= '0;
      id1       <= '0;
      cnt1      <= '0;
      chk1      <= '0;
      len       <= '0;
      idx       <= '0;
      id_ok     <= 1'b0;
      tmo       <= '0;
      cmd       <= '0;
      cmd_arg   <= '0;
      cmd_len   <= '0;
      cmd_flag  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      cmd_flag  <= 1'b0;
      frame_err <= 1'b0;
      if (rx_data_flag) begin
        tmo <= '0;
        case (state)
          S_ID1: begin
            id1    <= rx_data;
            sum    <= {8'h00, rx_data};
            buffer <= '0;
            idx    <= '0;
            state  <= S_ID2;
          end
          S_ID2: begin
            id_ok <= {id1, rx_data} == DEV_ID;
            sum   <= sum_next;
            state <= S_CNT1;
          end
          S_CNT1: begin
            cnt1  <= rx_data;
            sum   <= sum_next;
            state <= S_CNT2;
          end
          S_CNT2: begin
            sum       <= sum_next;
            len       <= rx_data[2:0];
            state     <= cnt_ok ? S_DATA : S_ID1;
            frame_err <= !cnt_ok;
          end
          S_DATA: begin
            // ~idx == 3-idx: first payload byte lands in [31:24]
            buffer[{~idx, 3'b000} +: 8] <= rx_data;
            sum   <= sum_next;
            idx   <= idx + 2'd1;
            state <= ({1'b0, idx} == len - 3'd1) ? S_CHK1 : S_DATA;
          end
          S_CHK1: begin
            chk1  <= rx_data;
            state <= S_CHK2;
          end
          S_CHK2: begin
            state <= S_ID1;
            if ({chk1, rx_data} != sum) frame_err <= 1'b1;
            else if (id_ok) begin
              cmd      <= buffer[31:24];
              cmd_arg  <= buffer[23:0];
              cmd_len  <= len;
              cmd_flag <= 1'b1;
            end
          end
          default: state <= S_ID1;
        endcase
      end else if (state == S_ID1) tmo <= '0;
      else if (tmo == TW'(TIMEOUT_CYC - 1)) begin
        state     <= S_ID1;
        frame_err <= 1'b1;
        tmo       <= '0;
      end else tmo <= tmo + 1'b1;
    end
  end
endmodule

// File: tb/tb_rx_frame_parser.sv
// tb_rx_frame_parser: directed per-scenario tests for rx_frame_parser with hand-computed expectations.
module tb_rx_frame_parser;
  localparam int TO = 20;
  typedef logic [7:0] seq_t [10];
  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_data_flag = 1'b0;
  logic [7:0]  cmd;
  logic [23:0] cmd_arg;
  logic [2:0]  cmd_len;
  logic        cmd_flag, frame_err, rx_busy;
  int vectors = 0;
  int miscompares = 0;

  rx_frame_parser #(.DEV_ID(16'h0001), .MAX_LEN(4), .TIMEOUT_CYC(TO)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .rx_data(rx_data), .rx_data_flag(rx_data_flag),
    .cmd(cmd), .cmd_arg(cmd_arg), .cmd_len(cmd_len), .cmd_flag(cmd_flag),
    .frame_err(frame_err), .rx_busy(rx_busy)
  );

  always #5 sys_clk = ~sys_clk;

  // Called at a negedge; returns at the negedge after the byte was clocked in.
  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_data_flag = 1'b1;
    @(negedge sys_clk);
    rx_data_flag = 1'b0;
  endtask

  task automatic send_seq(input seq_t s, input int n);
    for (int i = 0; i < n; i++) send_byte(s[i]);
  endtask

  task automatic test_reset;
    #1;
    vectors++; if (cmd !== 8'h00) begin miscompares++; $display("FAIL reset_cmd got=%h exp=00", cmd); end
    vectors++; if (cmd_arg !== 24'h0) begin miscompares++; $display("FAIL reset_cmd_arg got=%h exp=0", cmd_arg); end
    vectors++; if (cmd_len !== 3'd0) begin miscompares++; $display("FAIL reset_cmd_len got=%0d exp=0", cmd_len); end
    vectors++; if ({cmd_flag, frame_err, rx_busy} !== 3'b000) begin miscompares++; $display("FAIL reset_flags got=%b exp=000", {cmd_flag, frame_err, rx_busy}); end
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b1;
    @(negedge sys_clk);
  endtask

  task automatic test_one_byte;
    send_seq('{8'h00, 8'h01, 8'h00, 8'h01, 8'h05, 8'h00, 8'h07, 8'h00, 8'h00, 8'h00}, 7);
    vectors++; if ({cmd_flag, frame_err} !== 2'b10) begin miscompares++; $display("FAIL one_flags got=%b exp=10", {cmd_flag, frame_err}); end
    vectors++; if ({cmd, cmd_arg, cmd_len} !== {8'h05, 24'h0, 3'd1}) begin miscompares++; $display("FAIL one_cmd got=%h/%h/%0d exp=05/000000/1", cmd, cmd_arg, cmd_len); end
    @(negedge sys_clk);
    vectors++; if (cmd_flag !== 1'b0) begin miscompares++; $display("FAIL one_pulse_width got=%b exp=0", cmd_flag); end
  endtask

  task automatic test_four_byte;
    send_seq('{8'h00, 8'h01, 8'h00, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'hAF}, 10);
    vectors++; if ({cmd_flag, frame_err} !== 2'b10) begin miscompares++; $display("FAIL four_flags got=%b exp=10", {cmd_flag, frame_err}); end
    vectors++; if ({cmd, cmd_arg, cmd_len} !== {8'h11, 24'h223344, 3'd4}) begin miscompares++; $display("FAIL four_cmd got=%h/%h/%0d exp=11/223344/4", cmd, cmd_arg, cmd_len); end
    @(negedge sys_clk);
    vectors++; if (cmd_flag !== 1'b0) begin miscompares++; $display("FAIL four_pulse_width got=%b exp=0", cmd_flag); end
  endtask

  task automatic test_bad_checksum;
    send_seq('{8'h00, 8'h01, 8'h00, 8'h01, 8'h05, 8'h00, 8'h08, 8'h00, 8'h00, 8'h00}, 7);
    vectors++; if ({cmd_flag, frame_err} !== 2'b01) begin miscompares++; $display("FAIL badchk_flags got=%b exp=01", {cmd_flag, frame_err}); end
    vectors++; if ({cmd, cmd_arg, cmd_len} !== {8'h11, 24'h223344, 3'd4}) begin miscompares++; $display("FAIL badchk_hold got=%h/%h/%0d exp=11/223344/4", cmd, cmd_arg, cmd_len); end
    send_seq('{8'h00, 8'h01, 8'h00, 8'h01, 8'h05, 8'h00, 8'h07, 8'h00, 8'h00, 8'h00}, 7);
    vectors++; if ({cmd_flag, cmd} !== {1'b1, 8'h05}) begin miscompares++; $display("FAIL badchk_recover got=%b/%h exp=1/05", cmd_flag, cmd); end
    @(negedge sys_clk);
  endtask

  task automatic test_id_mismatch;
    send_seq('{8'h00, 8'h02, 8'h00, 8'h01, 8'h05, 8'h00, 8'h08, 8'h00, 8'h00, 8'h00}, 7);
    vectors++; if ({cmd_flag, frame_err, rx_busy} !== 3'b000) begin miscompares++; $display("FAIL idmis_flags got=%b exp=000", {cmd_flag, frame_err, rx_busy}); end
    @(negedge sys_clk);
  endtask

  task automatic test_len_error;
    send_seq('{8'h00, 8'h01, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 4);
    vectors++; if ({frame_err, rx_busy} !== 2'b10) begin miscompares++; $display("FAIL len5 got=%b exp=10", {frame_err, rx_busy}); end
    @(negedge sys_clk);
    vectors++; if (frame_err !== 1'b0) begin miscompares++; $display("FAIL len5_pulse_width got=%b exp=0", frame_err); end
    send_seq('{8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 4);
    vectors++; if ({frame_err, rx_busy} !== 2'b10) begin miscompares++; $display("FAIL len0 got=%b exp=10", {frame_err, rx_busy}); end
    @(negedge sys_clk);
  endtask

  task automatic test_timeout;
    int first = -1;
    int pulses = 0;
    send_seq('{8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 2);
    for (int i = 1; i <= TO + 10; i++) begin
      @(negedge sys_clk);
      if (frame_err) begin pulses++; if (first < 0) first = i; end
    end
    vectors++; if (pulses !== 1) begin miscompares++; $display("FAIL timeout_pulses got=%0d exp=1", pulses); end
    vectors++; if (first !== TO) begin miscompares++; $display("FAIL timeout_cycle got=%0d exp=%0d", first, TO); end
    vectors++; if (rx_busy !== 1'b0) begin miscompares++; $display("FAIL timeout_busy got=%b exp=0", rx_busy); end
    send_seq('{8'h00, 8'h01, 8'h00, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'hAF}, 10);
    vectors++; if ({cmd_flag, cmd_len} !== {1'b1, 3'd4}) begin miscompares++; $display("FAIL timeout_recover got=%b/%0d exp=1/4", cmd_flag, cmd_len); end
    @(negedge sys_clk);
  endtask

  task automatic test_back_to_back;
    send_seq('{8'h00, 8'h01, 8'h00, 8'h01, 8'h05, 8'h00, 8'h07, 8'h00, 8'h00, 8'h00}, 7);
    vectors++; if ({cmd_flag, cmd} !== {1'b1, 8'h05}) begin miscompares++; $display("FAIL b2b_first got=%b/%h exp=1/05", cmd_flag, cmd); end
    send_seq('{8'h00, 8'h01, 8'h00, 8'h02, 8'hA0, 8'hB0, 8'h01, 8'h53, 8'h00, 8'h00}, 8);
    vectors++; if ({cmd_flag, cmd, cmd_arg, cmd_len} !== {1'b1, 8'hA0, 24'hB00000, 3'd2}) begin miscompares++; $display("FAIL b2b_second got=%b/%h/%h/%0d exp=1/a0/b00000/2", cmd_flag, cmd, cmd_arg, cmd_len); end
    @(negedge sys_clk);
  endtask

  task automatic test_async_reset;
    send_seq('{8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3);
    #2 sys_rst = 1'b0;
    #1;
    vectors++; if ({cmd, cmd_arg, cmd_len} !== 35'h0) begin miscompares++; $display("FAIL arst_cmd got=%h/%h/%0d exp=00/000000/0", cmd, cmd_arg, cmd_len); end
    vectors++; if ({cmd_flag, frame_err, rx_busy} !== 3'b000) begin miscompares++; $display("FAIL arst_flags got=%b exp=000", {cmd_flag, frame_err, rx_busy}); end
    @(negedge sys_clk);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    send_seq('{8'h00, 8'h01, 8'h00, 8'h01, 8'h05, 8'h00, 8'h07, 8'h00, 8'h00, 8'h00}, 7);
    vectors++; if ({cmd_flag, frame_err, cmd} !== {2'b10, 8'h05}) begin miscompares++; $display("FAIL arst_recover got=%b/%b/%h exp=1/0/05", cmd_flag, frame_err, cmd); end
    @(negedge sys_clk);
  endtask

  initial begin
    test_reset;
    test_one_byte;
    test_four_byte;
    test_bad_checksum;
    test_four_byte;
    test_id_mismatch;
    test_len_error;
    test_timeout;
    test_back_to_back;
    test_async_reset;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
